// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file arbiter and the ID-stage decoder.
package regfile_pkg;

    localparam int RF_DATA_W = 8;
    localparam int RF_NREG   = 4;
    localparam int RF_ADDR_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } state_t;

    function automatic logic [RF_NREG-1:0] onehot4(input logic [RF_ADDR_W-1:0] addr);
        return RF_NREG'(1) << addr;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: combinational choice, registered last-granted pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       nReset,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       valid_o,
    output logic       gnt_o
);

    logic last_q, last_d;

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        valid_o = |req_i;
        gnt_o   = 1'b0;
        case (req_i)
            2'b10:   gnt_o = 1'b1;
            2'b11:   gnt_o = ~last_q;
            default: gnt_o = 1'b0;
        endcase
        last_d = (take_i && valid_o) ? gnt_o : last_q;
    end

    // Pointer starts at 1 so port 0 wins the first contested grant.
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) last_q <= 1'b1;
        else         last_q <= last_d;
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-port arbiter/sequencer in front of the register file: latch a request, drive the
// file for one SERVE cycle, capture read data, then pulse the granted port's ack.
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREG   = RF_NREG
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic                    req0,
    input  logic                    we0,
    input  logic [$clog2(NREG)-1:0] addr0,
    input  logic [DATA_W-1:0]       wdata0,
    output logic                    ack0,
    output logic [DATA_W-1:0]       rdata0,
    input  logic                    req1,
    input  logic                    we1,
    input  logic [$clog2(NREG)-1:0] addr1,
    input  logic [DATA_W-1:0]       wdata1,
    output logic                    ack1,
    output logic [DATA_W-1:0]       rdata1,
    output logic [DATA_W-1:0]       rf_A,
    output logic [NREG-1:0]         rf_RegX,
    output logic                    rf_RegCE,
    input  logic [DATA_W-1:0]       rf_out,
    output logic                    busy
);

    state_t              state_q, state_d;
    logic                port_q, port_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [DATA_W-1:0]   rf_a_q, rf_a_d;
    logic [NREG-1:0]     rf_regx_q, rf_regx_d;
    logic                rf_regce_q, rf_regce_d;
    logic                busy_q, busy_d;

    logic                gnt_valid, gnt_port;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .nReset  (nReset),
        .req_i   ({req1, req0}),
        .take_i  (state_q == IDLE),
        .valid_o (gnt_valid),
        .gnt_o   (gnt_port)
    );

    // Outputs are computed one state ahead so every port comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        rf_a_d     = rf_a_q;
        rf_regx_d  = '0;
        rf_regce_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d    = SERVE;
                    port_d     = gnt_port;
                    rf_regx_d  = onehot4(gnt_port ? addr1 : addr0);
                    rf_a_d     = gnt_port ? wdata1 : wdata0;
                    rf_regce_d = gnt_port ? we1 : we0;
                end
            end
            SERVE: begin
                state_d = ACK;
                ack0_d  = ~port_q;
                ack1_d  = port_q;
                if (!rf_regce_q) begin
                    if (port_q) rdata1_d = rf_out;
                    else        rdata0_d = rf_out;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            port_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rf_a_q     <= '0;
            rf_regx_q  <= '0;
            rf_regce_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            rf_a_q     <= rf_a_d;
            rf_regx_q  <= rf_regx_d;
            rf_regce_q <= rf_regce_d;
            busy_q     <= busy_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign rf_A     = rf_a_q;
    assign rf_RegX  = rf_regx_q;
    assign rf_RegCE = rf_regce_q;
    assign busy     = busy_q;

endmodule
